// File: rtl/red_pkg.sv
// Shared constants and helpers for the Barrett modular-reduction blocks
// (Kyber and Dilithium parameter sets).
package red_pkg;

    localparam longint unsigned KYBER_Q = 64'd3329;
    localparam int unsigned     KYBER_W = 32'd12;
    localparam int unsigned     KYBER_K = 32'd24;

    localparam longint unsigned DIL_Q = 64'd8380417;
    localparam int unsigned     DIL_W = 32'd23;
    localparam int unsigned     DIL_K = 32'd46;

    // Barrett constant floor(2^k / q); k must stay below 64.
    function automatic longint unsigned barrett_m(input longint unsigned q, input int unsigned k);
        return (64'd1 << k) / q;
    endfunction

endpackage

// File: rtl/barrett_mul_pipe_chk.sv
// Simulation-only property checks for barrett_mul_pipe: legal operand range
// on accepted inputs and fully reduced results on the output.
module barrett_mul_pipe_chk #(
    parameter longint unsigned Q     = 64'd3329,
    parameter int unsigned     W     = 32'd12,
    parameter int unsigned     TAG_W = 32'd4
) (
    input logic             clk_i,
    input logic             rst_i,
    input logic             in_valid_i,
    input logic             mode_i,
    input logic [W-1:0]     a_i,
    input logic [W-1:0]     b_i,
    input logic             out_valid_i,
    input logic [W-1:0]     result_i,
    input logic [TAG_W-1:0] tag_i
);

    // Multiply mode needs both operands reduced; reduce-only needs {a,b} < Q^2.
    property p_operands_in_range;
        @(posedge clk_i) disable iff (rst_i)
        in_valid_i |-> (mode_i ? (64'({a_i, b_i}) < (Q * Q))
                               : ((64'(a_i) < Q) && (64'(b_i) < Q)));
    endproperty
    a_operands_in_range: assert property (p_operands_in_range);

    property p_result_reduced;
        @(posedge clk_i) disable iff (rst_i)
        out_valid_i |-> ((64'(result_i) < Q) && (^tag_i !== 1'bx));
    endproperty
    a_result_reduced: assert property (p_result_reduced);

endmodule

// File: rtl/subtractor_n.sv
// Generic N-bit subtractor returning difference and borrow-out.
module subtractor_n #(
    parameter int unsigned nb_bit = 32'd8
) (
    input  logic [nb_bit-1:0] a_i,
    input  logic [nb_bit-1:0] b_i,
    output logic [nb_bit-1:0] diff_o,
    output logic              borrow_o
);

    assign {borrow_o, diff_o} = {1'b0, a_i} - {1'b0, b_i};

endmodule

// File: rtl/barrett_mul_pipe.sv
// Three-stage pipelined (a*b) mod Q using Barrett reduction, with valid/ready
// flow control on both sides and a reduce-only mode.
module barrett_mul_pipe
    import red_pkg::*;
#(
    parameter longint unsigned Q     = KYBER_Q,
    parameter int unsigned     W     = KYBER_W,
    parameter int unsigned     K     = KYBER_K,
    parameter int unsigned     TAG_W = 32'd4
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [W-1:0]     a_i,
    input  logic [W-1:0]     b_i,
    input  logic             mode_i,
    input  logic [TAG_W-1:0] tag_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [W-1:0]     result_o,
    output logic [TAG_W-1:0] tag_o
);

    localparam longint unsigned M   = barrett_m(Q, K);
    localparam int unsigned     P_W = 2 * W;
    localparam int unsigned     R_W = W + 1;
    localparam int unsigned     X_W = P_W + K + 1;
    localparam logic [K:0]      M_V = M[K:0];
    localparam logic [W:0]      Q_V = Q[W:0];

    typedef struct packed {
        logic             valid;
        logic [P_W-1:0]   p;
        logic [TAG_W-1:0] tag;
    } s1_t;

    typedef struct packed {
        logic             valid;
        logic [P_W-1:0]   p;
        logic [R_W-1:0]   qhat;
        logic [TAG_W-1:0] tag;
    } s2_t;

    s1_t              s1_q, s1_d;
    s2_t              s2_q, s2_d;
    logic             out_valid_q, out_valid_d;
    logic [W-1:0]     result_q, result_d;
    logic [TAG_W-1:0] tag_q, tag_d;

    logic             en1_s, en2_s, en3_s;
    logic [P_W-1:0]   p_in_s;
    logic [R_W-1:0]   qhat_s, r_s, rq_s;
    logic             borrow_s;
    logic [W-1:0]     result_s;

    // A stage loads when it is empty or its current content moves on this edge.
    assign en3_s      = ~out_valid_q | out_ready_i;
    assign en2_s      = ~s2_q.valid | en3_s;
    assign en1_s      = ~s1_q.valid | en2_s;
    assign in_ready_o = en1_s;

    // S1 operand: full product, or the concatenated operands in reduce-only mode.
    always_comb begin
        case (mode_i)
            1'b0:    p_in_s = P_W'(a_i) * P_W'(b_i);
            1'b1:    p_in_s = {a_i, b_i};
            default: p_in_s = '0;
        endcase
    end

    // r only needs W+1 bits: the true remainder is below 2Q < 2^(W+1).
    assign qhat_s = R_W'((X_W'(s1_q.p) * X_W'(M_V)) >> K);
    assign r_s    = R_W'(s2_q.p - P_W'(s2_q.qhat) * P_W'(Q_V));

    subtractor_n #(
        .nb_bit (R_W)
    ) u_sub (
        .a_i      (r_s),
        .b_i      (Q_V),
        .diff_o   (rq_s),
        .borrow_o (borrow_s)
    );

    assign result_s = W'(borrow_s ? r_s : rq_s);

    // Next-state for all pipeline stages.
    always_comb begin
        s1_d        = s1_q;
        s2_d        = s2_q;
        out_valid_d = out_valid_q;
        result_d    = result_q;
        tag_d       = tag_q;
        if (en1_s) begin
            s1_d.valid = in_valid_i;
            if (in_valid_i) begin
                s1_d.p   = p_in_s;
                s1_d.tag = tag_i;
            end else begin
                s1_d.p   = s1_q.p;
                s1_d.tag = s1_q.tag;
            end
        end else begin
            s1_d = s1_q;
        end
        if (en2_s) begin
            s2_d.valid = s1_q.valid;
            if (s1_q.valid) begin
                s2_d.p    = s1_q.p;
                s2_d.qhat = qhat_s;
                s2_d.tag  = s1_q.tag;
            end else begin
                s2_d.p    = s2_q.p;
                s2_d.qhat = s2_q.qhat;
                s2_d.tag  = s2_q.tag;
            end
        end else begin
            s2_d = s2_q;
        end
        if (en3_s) begin
            out_valid_d = s2_q.valid;
            if (s2_q.valid) begin
                result_d = result_s;
                tag_d    = s2_q.tag;
            end else begin
                result_d = result_q;
                tag_d    = tag_q;
            end
        end else begin
            out_valid_d = out_valid_q;
        end
    end

    // Pipeline registers; reset drops every in-flight operation.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            s1_q        <= '0;
            s2_q        <= '0;
            out_valid_q <= 1'b0;
            result_q    <= '0;
            tag_q       <= '0;
        end else begin
            s1_q        <= s1_d;
            s2_q        <= s2_d;
            out_valid_q <= out_valid_d;
            result_q    <= result_d;
            tag_q       <= tag_d;
        end
    end

    assign out_valid_o = out_valid_q;
    assign result_o    = result_q;
    assign tag_o       = tag_q;

    barrett_mul_pipe_chk #(
        .Q     (Q),
        .W     (W),
        .TAG_W (TAG_W)
    ) u_chk (
        .clk_i       (clk_i),
        .rst_i       (rst_i),
        .in_valid_i  (in_valid_i),
        .mode_i      (mode_i),
        .a_i         (a_i),
        .b_i         (b_i),
        .out_valid_i (out_valid_q),
        .result_i    (result_q),
        .tag_i       (tag_q)
    );

endmodule

// File: tb/tb_barrett_mul_pipe.sv
// Scoreboard bench for barrett_mul_pipe: Kyber and Dilithium instances, directed
// vectors, back-to-back, back-pressure, reduce-only and mid-flight reset.
module tb_barrett_mul_pipe;

    typedef struct {
        longint res;
        int     tag;
        int     cyc;
        bit     lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   cyc = 0;
    int   n_pass = 0;
    int   n_total = 0;

    exp_t kq[$];
    exp_t dq[$];
    exp_t ke, de;

    logic        k_in_valid = 1'b0, k_in_ready, k_mode = 1'b0, k_out_valid, k_out_ready = 1'b1;
    logic [11:0] k_a = '0, k_b = '0, k_result;
    logic [3:0]  k_tag_in = '0, k_tag;

    logic        d_in_valid = 1'b0, d_in_ready, d_mode = 1'b0, d_out_valid, d_out_ready = 1'b1;
    logic [22:0] d_a = '0, d_b = '0, d_result;
    logic [3:0]  d_tag_in = '0, d_tag;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    barrett_mul_pipe u_kyber (
        .clk_i (clk), .rst_i (rst),
        .in_valid_i (k_in_valid), .in_ready_o (k_in_ready),
        .a_i (k_a), .b_i (k_b), .mode_i (k_mode), .tag_i (k_tag_in),
        .out_valid_o (k_out_valid), .out_ready_i (k_out_ready),
        .result_o (k_result), .tag_o (k_tag)
    );

    barrett_mul_pipe #(
        .Q (red_pkg::DIL_Q), .W (red_pkg::DIL_W), .K (red_pkg::DIL_K), .TAG_W (4)
    ) u_dil (
        .clk_i (clk), .rst_i (rst),
        .in_valid_i (d_in_valid), .in_ready_o (d_in_ready),
        .a_i (d_a), .b_i (d_b), .mode_i (d_mode), .tag_i (d_tag_in),
        .out_valid_o (d_out_valid), .out_ready_i (d_out_ready),
        .result_o (d_result), .tag_o (d_tag)
    );

    task automatic check(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    endtask

    task automatic k_issue(input logic [11:0] a, input logic [11:0] b, input logic m,
                           input logic [3:0] t, input longint e, input bit lat);
        int g = 0;
        exp_t x;
        k_in_valid = 1'b1; k_a = a; k_b = b; k_mode = m; k_tag_in = t;
        @(negedge clk);
        while (!k_in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!k_in_ready) begin
            n_total++;
            $display("FAIL k_accept_timeout: in_ready stayed %0d, expected 1", k_in_ready);
        end else begin
            x.res = e; x.tag = int'(t); x.cyc = cyc; x.lat = lat;
            kq.push_back(x);
        end
        @(posedge clk); #1;
        k_in_valid = 1'b0;
    endtask

    task automatic d_issue(input logic [22:0] a, input logic [22:0] b,
                           input logic [3:0] t, input longint e, input bit lat);
        int g = 0;
        exp_t x;
        d_in_valid = 1'b1; d_a = a; d_b = b; d_mode = 1'b0; d_tag_in = t;
        @(negedge clk);
        while (!d_in_ready && g < 100) begin
            @(negedge clk);
            g++;
        end
        if (!d_in_ready) begin
            n_total++;
            $display("FAIL d_accept_timeout: in_ready stayed %0d, expected 1", d_in_ready);
        end else begin
            x.res = e; x.tag = int'(t); x.cyc = cyc; x.lat = lat;
            dq.push_back(x);
        end
        @(posedge clk); #1;
        d_in_valid = 1'b0;
    endtask

    task automatic wait_drain();
        int g = 0;
        while ((kq.size() != 0 || dq.size() != 0) && g < 500) begin
            @(posedge clk);
            g++;
        end
        if (kq.size() != 0 || dq.size() != 0) begin
            n_total++;
            $display("FAIL drain_timeout: %0d kyber and %0d dilithium results outstanding, expected 0",
                     kq.size(), dq.size());
        end
        repeat (4) @(posedge clk);
        #1;
    endtask

    // Kyber monitor: pop expectation on every output transfer.
    always @(negedge clk) begin
        if (!rst && k_out_valid && k_out_ready) begin
            if (kq.size() == 0) begin
                n_total++;
                $display("FAIL k_spurious: got result %0d tag %0d, expected no output", k_result, k_tag);
            end else begin
                ke = kq.pop_front();
                check("k_result", longint'(k_result), ke.res);
                check("k_tag", longint'(k_tag), longint'(ke.tag));
                if (ke.lat) check("k_latency", longint'(cyc - ke.cyc), 64'sd3);
            end
        end
    end

    // Dilithium monitor.
    always @(negedge clk) begin
        if (!rst && d_out_valid && d_out_ready) begin
            if (dq.size() == 0) begin
                n_total++;
                $display("FAIL d_spurious: got result %0d tag %0d, expected no output", d_result, d_tag);
            end else begin
                de = dq.pop_front();
                check("d_result", longint'(d_result), de.res);
                check("d_tag", longint'(d_tag), longint'(de.tag));
                if (de.lat) check("d_latency", longint'(cyc - de.cyc), 64'sd3);
            end
        end
    end

    initial begin
        logic [11:0] ta[4];
        logic [11:0] tb[4];
        longint      te[4];
        logic [23:0] rv[3];
        longint      re[3];
        logic [11:0] ra, rb;
        logic [22:0] da, db;
        logic [3:0]  rt;
        int          c0;
        bit          done;

        ta = '{12'd3328, 12'd2000, 12'd1234, 12'd0};
        tb = '{12'd3328, 12'd2, 12'd1, 12'd3000};
        te = '{64'sd1, 64'sd671, 64'sd1234, 64'sd0};
        rv = '{24'd11075584, 24'd3329, 24'd3328};
        re = '{64'sd1, 64'sd0, 64'sd3328};

        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check("reset_out_valid", longint'(k_out_valid), 64'sd0);
        check("reset_result", longint'(k_result), 64'sd0);
        check("reset_tag", longint'(k_tag), 64'sd0);
        check("reset_in_ready", longint'(k_in_ready), 64'sd1);
        check("reset_d_out_valid", longint'(d_out_valid), 64'sd0);
        @(posedge clk); #1;

        for (int i = 0; i < 4; i++) k_issue(ta[i], tb[i], 1'b0, 4'(i + 1), te[i], 1'b1);
        for (int i = 0; i < 3; i++) k_issue(rv[i][23:12], rv[i][11:0], 1'b1, 4'(i + 8), re[i], 1'b1);
        wait_drain();

        c0 = cyc;
        for (int i = 0; i < 200; i++) begin
            ra = 12'($urandom_range(0, 3328));
            rb = 12'($urandom_range(0, 3328));
            rt = 4'($urandom_range(0, 15));
            k_issue(ra, rb, 1'b0, rt, (longint'(ra) * longint'(rb)) % 64'sd3329, 1'b1);
        end
        check("k_b2b_cycles", longint'(cyc - c0), 64'sd200);
        wait_drain();

        k_out_ready = 1'b0;
        fork
            begin
                k_issue(12'd5, 12'd7, 1'b0, 4'hA, 64'sd35, 1'b0);
                k_issue(12'd100, 12'd100, 1'b0, 4'hB, 64'sd13, 1'b0);
                k_issue(12'd3000, 12'd3000, 1'b0, 4'hC, 64'sd1713, 1'b0);
                k_issue(12'd1, 12'd3328, 1'b0, 4'hD, 64'sd3328, 1'b0);
            end
            begin
                for (int i = 0; i < 6; i++) begin
                    @(negedge clk);
                    if (i >= 3) begin
                        check("bp_in_ready", longint'(k_in_ready), 64'sd0);
                        check("bp_out_valid", longint'(k_out_valid), 64'sd1);
                        check("bp_result_hold", longint'(k_result), 64'sd35);
                        check("bp_tag_hold", longint'(k_tag), 64'sd10);
                    end
                end
                @(posedge clk); #1;
                k_out_ready = 1'b1;
            end
        join
        wait_drain();

        done = 1'b0;
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    ra = 12'($urandom_range(0, 3328));
                    rb = 12'($urandom_range(0, 3328));
                    rt = 4'($urandom_range(0, 15));
                    k_issue(ra, rb, 1'b0, rt, (longint'(ra) * longint'(rb)) % 64'sd3329, 1'b0);
                end
                done = 1'b1;
            end
            begin
                while (!done) begin
                    @(posedge clk); #1;
                    k_out_ready = 1'($urandom_range(0, 1));
                end
                k_out_ready = 1'b1;
            end
        join
        wait_drain();

        k_out_ready = 1'b0;
        k_issue(12'd7, 12'd8, 1'b0, 4'h1, 64'sd56, 1'b0);
        k_issue(12'd9, 12'd10, 1'b0, 4'h2, 64'sd90, 1'b0);
        k_issue(12'd11, 12'd12, 1'b0, 4'h3, 64'sd132, 1'b0);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        kq.delete();
        @(negedge clk);
        check("rst_out_valid", longint'(k_out_valid), 64'sd0);
        check("rst_in_ready", longint'(k_in_ready), 64'sd1);
        @(posedge clk); #1;
        k_out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("rst_no_emit", longint'(k_out_valid), 64'sd0);
        end
        @(posedge clk); #1;
        k_issue(12'd12, 12'd12, 1'b0, 4'h6, 64'sd144, 1'b1);
        wait_drain();

        d_issue(23'd8380416, 23'd8380416, 4'h1, 64'sd1, 1'b1);
        d_issue(23'd4190209, 23'd2, 4'h2, 64'sd1, 1'b1);
        for (int i = 0; i < 1000; i++) begin
            da = 23'($urandom_range(0, 8380416));
            db = 23'($urandom_range(0, 8380416));
            rt = 4'($urandom_range(0, 15));
            d_issue(da, db, rt, (longint'(da) * longint'(db)) % 64'sd8380417, 1'b1);
        end
        wait_drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
